enemy_hit_ctrl: RTL

ENEMY_HIT_CTRL -- requirements
Module: enemy_hit_ctrl

---
 rtl/enemy_hit_ctrl_pkg.sv | 12 +
 rtl/enemy_hit_ctrl_hitbox_cmp.sv | 32 +++
 rtl/enemy_hit_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/enemy_hit_ctrl_pkg.sv
// Shared definitions for the enemy hit controller: FSM encoding and datapath widths.
package enemy_hit_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_ALIVE    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_DYING    = 2'd2,
        ST_DEAD     = 2'd3
    } state_t;

    localparam int COORD_W = 11;
    localparam int HP_W    = 4;
endpackage

// File: rtl/enemy_hit_ctrl_hitbox_cmp.sv
// Combinational overlap test of one missile against the enemy hitbox.
// Sums are computed one bit wider than the coordinates so they cannot wrap.
module hitbox_cmp
    import enemy_hit_ctrl_pkg::*;
#(
    parameter int HALF_WIDTH = 25,
    parameter int HEIGHT     = 50
) (
    input  logic [COORD_W-1:0] xpos_enemy,
    input  logic [COORD_W-1:0] ypos_enemy,
    input  logic [COORD_W-1:0] xpos_missile,
    input  logic [COORD_W-1:0] ypos_missile,
    input  logic               valid,
    output logic               overlap
);
    localparam int EXT_W = COORD_W + 1;
    localparam logic [EXT_W-1:0] HW = EXT_W'(HALF_WIDTH);
    localparam logic [EXT_W-1:0] HT = EXT_W'(HEIGHT);

    logic [EXT_W-1:0] xe, ye, xm, ym, xl, xr, yb;

    assign xe = {1'b0, xpos_enemy};
    assign ye = {1'b0, ypos_enemy};
    assign xm = {1'b0, xpos_missile};
    assign ym = {1'b0, ypos_missile};
    assign xr = xe + HW;
    assign yb = ye + HT;
    // Left edge clamps at the screen border instead of underflowing.
    assign xl = (xe >= HW) ? (xe - HW) : '0;

    assign overlap = valid && (xm >= xl) && (xm <= xr) && (ym >= ye) && (ym <= yb);
endmodule

// File: rtl/enemy_hit_ctrl.sv
// Enemy hit-point FSM: detects missile hits, times invulnerability and the
// explosion with one shared down-counter, and strobes kill for scoring.
module enemy_hit_ctrl
    import enemy_hit_ctrl_pkg::*;
#(
    parameter int N_MISSILES   = 2,
    parameter int HP_MAX       = 3,
    parameter int HALF_WIDTH   = 25,
    parameter int HEIGHT       = 50,
    parameter int COOLDOWN     = 8,
    parameter int DYING_CYCLES = 16
) (
    input  logic                            pclk,
    input  logic                            rst,
    input  logic                            level_change,
    input  logic [COORD_W-1:0]              xpos_enemy,
    input  logic [COORD_W-1:0]              ypos_enemy,
    input  logic [COORD_W*N_MISSILES-1:0]   xpos_missile,
    input  logic [COORD_W*N_MISSILES-1:0]   ypos_missile,
    input  logic [N_MISSILES-1:0]           missile_valid,
    output logic                            on_out,
    output logic                            dying_out,
    output logic [N_MISSILES-1:0]           hit_ack,
    output logic                            kill_pulse,
    output logic [HP_W-1:0]                 hp_out
);
    localparam int T_MAX = (COOLDOWN > DYING_CYCLES) ? COOLDOWN : DYING_CYCLES;
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam logic [HP_W-1:0]  HP_INIT  = HP_W'(HP_MAX);
    localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] DY_LOAD  = CNT_W'(DYING_CYCLES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [N_MISSILES-1:0]   overlap;
    logic [N_MISSILES-1:0]   hit_sel;
    logic                    hit_any;

    for (genvar g = 0; g < N_MISSILES; g++) begin : g_cmp
        hitbox_cmp #(
            .HALF_WIDTH (HALF_WIDTH),
            .HEIGHT     (HEIGHT)
        ) u_cmp (
            .xpos_enemy   (xpos_enemy),
            .ypos_enemy   (ypos_enemy),
            .xpos_missile (xpos_missile[COORD_W*g +: COORD_W]),
            .ypos_missile (ypos_missile[COORD_W*g +: COORD_W]),
            .valid        (missile_valid[g]),
            .overlap      (overlap[g])
        );
    end

    // Lowest-index overlapping channel wins; the rest are ignored this cycle.
    always_comb begin
        hit_sel = '0;
        hit_any = 1'b0;
        for (int i = 0; i < N_MISSILES; i++) begin
            if (overlap[i] && !hit_any) begin
                hit_sel[i] = 1'b1;
                hit_any    = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ST_ALIVE;
            cnt        <= '0;
            hp_out     <= HP_INIT;
            on_out     <= 1'b1;
            dying_out  <= 1'b0;
            hit_ack    <= '0;
            kill_pulse <= 1'b0;
        end else begin
            hit_ack    <= '0;
            kill_pulse <= 1'b0;
            if (level_change) begin
                state     <= ST_ALIVE;
                cnt       <= '0;
                hp_out    <= HP_INIT;
                on_out    <= 1'b1;
                dying_out <= 1'b0;
            end else begin
                case (state)
                    ST_ALIVE: begin
                        if (hit_any) begin
                            hit_ack <= hit_sel;
                            if (hp_out > 4'd1) begin
                                hp_out <= hp_out - 4'd1;
                                state  <= ST_COOLDOWN;
                                cnt    <= CD_LOAD;
                            end else begin
                                hp_out     <= '0;
                                state      <= ST_DYING;
                                cnt        <= DY_LOAD;
                                kill_pulse <= 1'b1;
                                on_out     <= 1'b0;
                                dying_out  <= 1'b1;
                            end
                        end
                    end
                    ST_COOLDOWN: begin
                        if (cnt == '0) state <= ST_ALIVE;
                        else           cnt   <= cnt - 1'b1;
                    end
                    ST_DYING: begin
                        if (cnt == '0) begin
                            state     <= ST_DEAD;
                            dying_out <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
